// File: rtl/keyboard_buffer_ctrl.sv
// PS/2 keyboard ping-pong buffer sequencer: fills one half with key bytes,
// closes a line on terminator or full half, and hands it to the CPU.
module keyboard_buffer_ctrl #(
    parameter int unsigned    AW        = 6,
    parameter int unsigned    DW        = 8,
    parameter logic [DW-1:0]  TERM_CODE = 8'h5A
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [DW-1:0] key_code,
    input  logic          cpu_done,
    output logic          wea,
    output logic [AW-1:0] ps2_addr,
    output logic [DW-1:0] ps2_data,
    output logic          buf_slt,
    output logic          buf_ready,
    output logic [AW:0]   buf_len,
    output logic [7:0]    drop_cnt
);

    typedef enum logic [1:0] {
        FILL,
        SWAP_PEND,
        WAIT_CPU
    } state_t;

    localparam logic [AW-1:0] PTR_MAX = '1;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   line_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            wr_ptr    <= '0;
            line_len  <= '0;
            wea       <= 1'b0;
            ps2_addr  <= '0;
            ps2_data  <= '0;
            buf_slt   <= 1'b0;
            buf_ready <= 1'b0;
            buf_len   <= '0;
            drop_cnt  <= '0;
        end else begin
            wea <= 1'b0;
            unique case (state)
                FILL: begin
                    if (key_valid) begin
                        wea      <= 1'b1;
                        ps2_addr <= wr_ptr;
                        ps2_data <= key_code;
                        wr_ptr   <= wr_ptr + 1'b1;
                        if (key_code == TERM_CODE || wr_ptr == PTR_MAX) begin
                            state    <= SWAP_PEND;
                            line_len <= {1'b0, wr_ptr} + 1'b1;
                        end
                    end
                    if (cpu_done && buf_ready)
                        buf_ready <= 1'b0;
                end
                SWAP_PEND: begin
                    if (key_valid && drop_cnt != 8'hFF)
                        drop_cnt <= drop_cnt + 8'd1;
                    // a release in this same cycle frees the CPU half in time
                    if (!buf_ready || cpu_done) begin
                        buf_slt   <= ~buf_slt;
                        buf_ready <= 1'b1;
                        buf_len   <= line_len;
                        wr_ptr    <= '0;
                        state     <= FILL;
                    end else begin
                        state <= WAIT_CPU;
                    end
                end
                WAIT_CPU: begin
                    if (key_valid && drop_cnt != 8'hFF)
                        drop_cnt <= drop_cnt + 8'd1;
                    if (cpu_done) begin
                        buf_slt   <= ~buf_slt;
                        buf_ready <= 1'b1;
                        buf_len   <= line_len;
                        wr_ptr    <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
